// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//   Removes a per-packet header of strip_cnt bytes (0..DATA_BYTE_WD-1) from
//   the front of an AXI-Stream packet and re-packs the remaining payload so
//   every output beat is left-aligned (byte 0 in the MSBs, MSB-aligned keep).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   valid_in/data_in/keep_in/last_in upstream beat; ready_in is the accept
//   valid_out/data_out/keep_out/last_out registered downstream beat;
//                                    ready_out is the downstream accept
//   valid_strip/strip_cnt            header-length descriptor, one per packet;
//                                    ready_strip is the accept (IDLE only)
//   drop_pkt                         one-cycle pulse when a packet carried no
//                                    payload after stripping
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
  output logic                    ready_strip,
  output logic                    drop_pkt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  // One extra bit so byte counts reach DATA_BYTE_WD without wrapping.
  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  // Top n bytes of a data word enabled.
  function automatic logic [DATA_WD-1:0] byte_mask(input logic [CW-1:0] n);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      if (CW'(i) < n) m[DATA_WD-1-8*i -: 8] = '1;
    return m;
  endfunction

  // Top n keep bits set.
  function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input logic [CW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      if (CW'(i) < n) m[DATA_BYTE_WD-1-i] = 1'b1;
    return m;
  endfunction

  // Byte shifts toward / away from byte 0; a shift of DATA_BYTE_WD yields 0.
  function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] d,
                                                   input logic [CW-1:0] n);
    return d << (32'(n) * 32'd8);
  endfunction

  function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] d,
                                                   input logic [CW-1:0] n);
    return d >> (32'(n) * 32'd8);
  endfunction

  logic [1:0]              state, state_nx;
  logic [CW-1:0]           s_q, s_nx;
  logic [CW-1:0]           r_q, r_nx;
  logic [DATA_WD-1:0]      res_q, res_nx;

  logic                    load_ok;
  logic                    accept_in;
  logic [CW-1:0]           k;
  logic [CW-1:0]           room;
  logic [DATA_WD-1:0]      merged;

  logic                    emit;
  logic [DATA_WD-1:0]      emit_data;
  logic [DATA_BYTE_WD-1:0] emit_keep;
  logic                    emit_last;
  logic                    drop_nx;

  assign load_ok     = ~valid_out | ready_out;
  assign ready_in    = ((state == FIRST) | (state == STREAM)) & load_ok;
  assign ready_strip = (state == IDLE) & rst_n;
  assign accept_in   = valid_in & ready_in;
  assign k           = popcount(keep_in);
  // Free byte slots after the residual; comparing k against this instead of
  // forming r+k keeps every intermediate within CW bits.
  assign room        = W_C - r_q;
  assign merged      = res_q | shr_bytes(data_in, r_q);

  always_comb begin
    state_nx  = state;
    s_nx      = s_q;
    r_nx      = r_q;
    res_nx    = res_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_keep = '0;
    emit_last = 1'b0;
    drop_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (valid_strip & ready_strip) begin
          s_nx     = {1'b0, strip_cnt};
          state_nx = FIRST;
        end
      end
      FIRST: begin
        if (accept_in) begin
          if (!last_in) begin
            res_nx   = shl_bytes(data_in, s_q);
            r_nx     = W_C - s_q;
            state_nx = STREAM;
          end else begin
            if (k > s_q) begin
              emit      = 1'b1;
              emit_data = shl_bytes(data_in, s_q) & byte_mask(k - s_q);
              emit_keep = keep_mask(k - s_q);
              emit_last = 1'b1;
            end else begin
              drop_nx = 1'b1;
            end
            state_nx = IDLE;
          end
        end
      end
      STREAM: begin
        if (accept_in) begin
          if (!last_in) begin
            emit      = 1'b1;
            emit_data = merged;
            emit_keep = '1;
            res_nx    = shl_bytes(data_in, room);
          end else if (k <= room) begin
            emit      = 1'b1;
            emit_data = merged & byte_mask(r_q + k);
            emit_keep = keep_mask(r_q + k);
            emit_last = 1'b1;
            state_nx  = IDLE;
          end else begin
            emit      = 1'b1;
            emit_data = merged;
            emit_keep = '1;
            res_nx    = shl_bytes(data_in, room);
            r_nx      = k - room;
            state_nx  = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_data = res_q & byte_mask(r_q);
          emit_keep = keep_mask(r_q);
          emit_last = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      r_q       <= '0;
      res_q     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      drop_pkt  <= 1'b0;
    end else begin
      state    <= state_nx;
      s_q      <= s_nx;
      r_q      <= r_nx;
      res_q    <= res_nx;
      drop_pkt <= drop_nx;
      // emit is only raised when the output register is free (load_ok).
      if (emit) begin
        valid_out <= 1'b1;
        data_out  <= emit_data;
        keep_out  <= emit_keep;
        last_out  <= emit_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
